// File: rtl/lsu_ctrl_if.sv
// AGU command/response, long-pipe write-back and DTCM port bundle for lsu_ctrl.
// The slave modport is the LSU's view; master is the surrounding exu/RAM view.
interface lsu_ctrl_if #(
  parameter int XLEN            = 32,
  parameter int DTCM_ADDR_WIDTH = 16,
  parameter int ITAG_WIDTH      = 1
);
  logic                         agu_cmd_valid;
  logic                         agu_cmd_ready;
  logic [DTCM_ADDR_WIDTH-1:0]   agu_cmd_addr;
  logic                         agu_cmd_read;
  logic [ITAG_WIDTH-1:0]        agu_cmd_itag;
  logic [1:0]                   agu_cmd_size;
  logic                         agu_cmd_usign;
  logic [XLEN-1:0]              agu_cmd_wdata;
  logic [XLEN/8-1:0]            agu_cmd_wmask;
  logic                         agu_rsp_valid;
  logic                         agu_rsp_ready;
  logic                         agu_rsp_err;
  logic                         lsu_wbck_o_valid;
  logic                         lsu_wbck_o_ready;
  logic [XLEN-1:0]              lsu_wbck_o_data;
  logic [ITAG_WIDTH-1:0]        lsu_wbck_o_itag;
  logic                         lsu_wbck_o_err;
  logic                         dtcm_cs;
  logic                         dtcm_we;
  logic [DTCM_ADDR_WIDTH-3:0]   dtcm_addr;
  logic [XLEN/8-1:0]            dtcm_wem;
  logic [XLEN-1:0]              dtcm_din;
  logic [XLEN-1:0]              dtcm_dout;

  modport slave (
    input  agu_cmd_valid, agu_cmd_addr, agu_cmd_read, agu_cmd_itag, agu_cmd_size,
           agu_cmd_usign, agu_cmd_wdata, agu_cmd_wmask, agu_rsp_ready,
           lsu_wbck_o_ready, dtcm_dout,
    output agu_cmd_ready, agu_rsp_valid, agu_rsp_err, lsu_wbck_o_valid,
           lsu_wbck_o_data, lsu_wbck_o_itag, lsu_wbck_o_err,
           dtcm_cs, dtcm_we, dtcm_addr, dtcm_wem, dtcm_din
  );

  modport master (
    output agu_cmd_valid, agu_cmd_addr, agu_cmd_read, agu_cmd_itag, agu_cmd_size,
           agu_cmd_usign, agu_cmd_wdata, agu_cmd_wmask, agu_rsp_ready,
           lsu_wbck_o_ready, dtcm_dout,
    input  agu_cmd_ready, agu_rsp_valid, agu_rsp_err, lsu_wbck_o_valid,
           lsu_wbck_o_data, lsu_wbck_o_itag, lsu_wbck_o_err,
           dtcm_cs, dtcm_we, dtcm_addr, dtcm_wem, dtcm_din
  );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store control: one AGU command at a time against a single-port DTCM,
// store completions on the AGU response port, loads on the long-pipe write-back.
module lsu_ctrl #(
  parameter int XLEN            = 32,
  parameter int DTCM_ADDR_WIDTH = 16,
  parameter int ITAG_WIDTH      = 1
) (
  input  logic        clk,
  input  logic        rst,
  lsu_ctrl_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, RD_WAIT, LD_WB, ST_RSP} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              off_q, off_d;
  logic [1:0]              size_q, size_d;
  logic                    usign_q, usign_d;
  logic [ITAG_WIDTH-1:0]   itag_q, itag_d;
  logic [XLEN-1:0]         data_q, data_d;
  logic                    lerr_q, lerr_d;
  logic                    serr_q, serr_d;

  logic                    misalign, hs, cs;
  logic [7:0]              b_lane;
  logic [15:0]             h_lane;
  logic [XLEN-1:0]         ld_ext;

  always_comb begin
    misalign = (bus.agu_cmd_size == 2'b11) ||
               (bus.agu_cmd_size == 2'b01 && bus.agu_cmd_addr[0]) ||
               (bus.agu_cmd_size == 2'b10 && bus.agu_cmd_addr[1:0] != 2'b00);
    hs = bus.agu_cmd_valid && (state_q == IDLE);
    cs = hs && !misalign;
  end

  // Lane select uses the offset latched at acceptance, since dout arrives a cycle later.
  always_comb begin
    b_lane = bus.dtcm_dout[{off_q, 3'b000} +: 8];
    h_lane = bus.dtcm_dout[{off_q[1], 4'b0000} +: 16];
    case (size_q)
      2'b00:   ld_ext = {{(XLEN-8){~usign_q & b_lane[7]}}, b_lane};
      2'b01:   ld_ext = {{(XLEN-16){~usign_q & h_lane[15]}}, h_lane};
      default: ld_ext = bus.dtcm_dout;
    endcase
  end

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    size_d  = size_q;
    usign_d = usign_q;
    itag_d  = itag_q;
    data_d  = data_q;
    lerr_d  = lerr_q;
    serr_d  = serr_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          if (bus.agu_cmd_read) begin
            itag_d = bus.agu_cmd_itag;
            if (misalign) begin
              lerr_d  = 1'b1;
              data_d  = '0;
              state_d = LD_WB;
            end else begin
              lerr_d  = 1'b0;
              off_d   = bus.agu_cmd_addr[1:0];
              size_d  = bus.agu_cmd_size;
              usign_d = bus.agu_cmd_usign;
              state_d = RD_WAIT;
            end
          end else begin
            serr_d  = misalign;
            state_d = ST_RSP;
          end
        end
      end
      RD_WAIT: begin
        data_d  = ld_ext;
        state_d = LD_WB;
      end
      LD_WB:   if (bus.lsu_wbck_o_ready) state_d = IDLE;
      ST_RSP:  if (bus.agu_rsp_ready)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      off_q   <= '0;
      size_q  <= '0;
      usign_q <= 1'b0;
      itag_q  <= '0;
      data_q  <= '0;
      lerr_q  <= 1'b0;
      serr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      size_q  <= size_d;
      usign_q <= usign_d;
      itag_q  <= itag_d;
      data_q  <= data_d;
      lerr_q  <= lerr_d;
      serr_q  <= serr_d;
    end
  end

  assign bus.agu_cmd_ready    = (state_q == IDLE);
  assign bus.agu_rsp_valid    = (state_q == ST_RSP);
  assign bus.agu_rsp_err      = serr_q;
  assign bus.lsu_wbck_o_valid = (state_q == LD_WB);
  assign bus.lsu_wbck_o_data  = data_q;
  assign bus.lsu_wbck_o_itag  = itag_q;
  assign bus.lsu_wbck_o_err   = lerr_q;

  assign bus.dtcm_cs   = cs;
  assign bus.dtcm_we   = cs && !bus.agu_cmd_read;
  assign bus.dtcm_addr = bus.agu_cmd_addr[DTCM_ADDR_WIDTH-1:2];
  assign bus.dtcm_wem  = (cs && !bus.agu_cmd_read) ? bus.agu_cmd_wmask : '0;
  assign bus.dtcm_din  = bus.agu_cmd_wdata;
endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store unit control: the responder for the EXU AGU command interface, and the source of the EXU long-pipe LSU write-back interface. It accepts one AGU memory command at a time and performs the access on the single-port DTCM SRAM. A store returns an AGU response; a load returns aligned, sign- or zero-extended data with its ITAG on the write-back port. It sits between exu (AGU side and longp write-back side) and the DTCM RAM macro.

## Interface
- XLEN, 32, data width
- DTCM_ADDR_WIDTH, 16, byte-address width of the DTCM
- ITAG_WIDTH, 1, instruction tag width, matching the OITF pointer
- clk  in  1  clock; everything is on the rising edge
- rst  in  1  reset; synchronous, active-high
- agu_cmd_valid  in  1  command valid
- agu_cmd_ready  out  1  command ready
- agu_cmd_addr  in  DTCM_ADDR_WIDTH  byte address
- agu_cmd_read  in  1  1 = load, 0 = store
- agu_cmd_itag  in  ITAG_WIDTH  tag of the load
- agu_cmd_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
- agu_cmd_usign  in  1  load zero-extend
- agu_cmd_wdata  in  XLEN  store data, already lane-replicated by the AGU
- agu_cmd_wmask  in  XLEN/8  store byte-lane enables
- agu_rsp_valid  out  1  store completion
- agu_rsp_ready  in  1  AGU accepts the completion
- agu_rsp_err  out  1  store was misaligned or illegal; no write occurred
- lsu_wbck_o_valid  out  1  load result valid, to exu lsu_wbck_i_valid
- lsu_wbck_o_ready  in  1  from exu lsu_wbck_i_ready
- lsu_wbck_o_data  out  XLEN  extended load data
- lsu_wbck_o_itag  out  ITAG_WIDTH  tag of the returning load
- lsu_wbck_o_err  out  1  load was misaligned or illegal; data is 0
- dtcm_cs  out  1  RAM chip select
- dtcm_we  out  1  RAM write enable
- dtcm_addr  out  DTCM_ADDR_WIDTH-2  word address = agu_cmd_addr[DTCM_ADDR_WIDTH-1:2]
- dtcm_wem  out  XLEN/8  RAM byte write mask
- dtcm_din  out  XLEN  RAM write data
- dtcm_dout  in  XLEN  RAM read data; valid the cycle after a read with cs=1, we=0

## Operation
- FSM states: IDLE, RD_WAIT, LD_WB, ST_RSP. Reset state is IDLE.
- agu_cmd_ready = (state == IDLE). The block holds at most one command outstanding.
- Misaligned command: size 01 with addr[0]=1, size 10 with addr[1:0]≠0, or size 11.
- dtcm_cs = agu_cmd_valid & agu_cmd_ready & aligned. dtcm_we = cs & ~read.
- dtcm_wem = agu_cmd_wmask when writing, else 0. dtcm_din = agu_cmd_wdata.
- RAM signals are combinational from the handshake cycle; the RAM is never accessed outside IDLE.
- IDLE, accepting an aligned load: latch addr[1:0], size, usign, itag; go to RD_WAIT.
- IDLE, accepting an aligned store: the write occurs in the same cycle; go to ST_RSP with err=0.
- IDLE, accepting a misaligned command: no RAM access.
  - Load: latch err=1, data=0; go to LD_WB.
  - Store: err=1; go to ST_RSP.
- RD_WAIT: capture data from dtcm_dout into the result register; go to LD_WB.
  - Byte: lane = dout[8*addr[1:0] +: 8]; sign bit 7.
  - Half: lane = dout[16*addr[1] +: 16]; sign bit 15.
  - Word: dout unchanged.
  - usign=1 zero-extends; usign=0 sign-extends.
- LD_WB: lsu_wbck_o_valid=1; data, itag and err come from registers. On lsu_wbck_o_ready, go to IDLE.
- ST_RSP: agu_rsp_valid=1, agu_rsp_err registered. On agu_rsp_ready, go to IDLE.
- Valid/ready rules: a valid, once asserted, stays high with stable payload until ready. Ready may be high before valid.

## Timing
- Reset values:
  - agu_cmd_ready = 1 (state IDLE after reset).
  - agu_rsp_valid, agu_rsp_err, lsu_wbck_o_valid, lsu_wbck_o_err = 0.
  - lsu_wbck_o_data = 0, lsu_wbck_o_itag = 0.
  - dtcm_cs, dtcm_we, dtcm_wem = 0.
- Load accepted in cycle N: RAM read in N, dout sampled in N+1, lsu_wbck_o_valid from N+2. Next command accepted no earlier than N+3.
- Store accepted in cycle N: RAM write in N, agu_rsp_valid from N+1. With ready high, next command at N+2.
- Misaligned load: lsu_wbck_o_valid at N+1, skipping RD_WAIT.
- Backpressure: while ready is low, the block stays in LD_WB or ST_RSP indefinitely with payload stable and agu_cmd_ready=0.
- Ready asserted the same cycle valid rises: one-cycle transfer, and the block is IDLE the next cycle.
- rst asserted in any state: IDLE on the next edge. The in-flight response is discarded and never presented. A store already written in its handshake cycle is not undone.
- agu_cmd_valid is ignored outside IDLE; no command is lost because ready is low.

## Test plan
- Store word 0xDEADBEEF to addr 0x0010, wmask 1111, then load word from 0x0010, itag 1 -> dtcm_addr 0x0004 with wem 1111. Store response err=0 one cycle later. Load wbck valid 2 cycles after acceptance with data 0xDEADBEEF and itag 1.
- RAM word at 0x0010 = 0x80FF7F01:
  - Signed byte load at 0x0013 -> 0xFFFFFF80.
  - Unsigned byte load at 0x0013 -> 0x00000080.
  - Signed half load at 0x0012 -> 0xFFFF80FF.
  - Signed byte load at 0x0010 -> 0x00000001.
- Half load at 0x0011 -> no dtcm_cs; wbck valid next cycle with err=1 and data 0. Word store at 0x0012 -> no write; agu_rsp_err=1.
- Load with lsu_wbck_o_ready held low for 5 cycles -> valid and data stable throughout, agu_cmd_ready=0, and a second pending command is not accepted. It is accepted 1 cycle after the ready handshake.
- Assert rst in the cycle after a load is accepted (RD_WAIT) -> no wbck valid ever. Next cycle: agu_cmd_ready=1 and all outputs at reset values.
- Back-to-back stores with agu_rsp_ready tied high -> one accepted every 2 cycles, byte stores with wmask 0001 and 1000 update only lanes 0 and 3, confirmed by a following word read.
